// File: rtl/operand_fetch.sv
// Purpose: 8-entry register file with write bypass that captures an ALU operand set (R, S, opcode).
// Latency: 1 cycle from accepted request to out_valid; write-back lands on the same edge it is presented.
// Backpressure: valid/ready; in_ready = !out_valid || out_ready, so a stalled set holds and blocks new requests.
module operand_fetch #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        RA,
  input  logic [2:0]        SA,
  input  logic [DATA_W-1:0] Imm,
  input  logic              S_Sel,
  input  logic [3:0]        Op_In,
  input  logic              W_En,
  input  logic [2:0]        WA,
  input  logic [DATA_W-1:0] WD,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] S,
  output logic [3:0]        Alu_OP
);

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] s;
    logic [3:0]        op;
  } opset_t;

  logic [DATA_W-1:0] regs [8];
  opset_t            cur_set;
  opset_t            nxt_set;
  logic              cur_vld;
  logic              accept;
  logic              wr_vld;
  logic [DATA_W-1:0] rd_r_dat;
  logic [DATA_W-1:0] rd_s_dat;

  // Handshake and bypassed register reads; address 0 is hard-wired to zero.
  always_comb begin
    in_ready = !cur_vld || out_ready;
    accept   = in_valid && in_ready;
    wr_vld   = W_En && (WA != 3'd0);

    rd_r_dat = '0;
    if (RA != 3'd0) begin
      rd_r_dat = (wr_vld && (WA == RA)) ? WD : regs[RA];
    end

    rd_s_dat = '0;
    if (SA != 3'd0) begin
      rd_s_dat = (wr_vld && (WA == SA)) ? WD : regs[SA];
    end

    nxt_set.r  = rd_r_dat;
    nxt_set.s  = S_Sel ? Imm : rd_s_dat;
    nxt_set.op = Op_In;
  end

  // Register file write-back, independent of the request handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_vld) begin
      regs[WA] <= WD;
    end
  end

  // Output operand set: load on accept, drop valid on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_vld <= 1'b0;
      cur_set <= '0;
    end else if (accept) begin
      cur_vld <= 1'b1;
      cur_set <= nxt_set;
    end else if (out_ready) begin
      cur_vld <= 1'b0;
    end
  end

  assign out_valid = cur_vld;
  assign R         = cur_set.r;
  assign S         = cur_set.s;
  assign Alu_OP    = cur_set.op;

endmodule

// File: tb/tb_operand_fetch.sv
// Purpose: self-checking bench for operand_fetch: directed scenarios plus randomized traffic against a reference model.
// Latency: model mirrors the one-cycle request-to-output behaviour; outputs checked every falling edge.
// Backpressure: out_ready is driven randomly to exercise stalls, consume-only and simultaneous consume/accept.
module tb_operand_fetch;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    RA;
  logic [2:0]    SA;
  logic [DW-1:0] Imm;
  logic          S_Sel;
  logic [3:0]    Op_In;
  logic          W_En;
  logic [2:0]    WA;
  logic [DW-1:0] WD;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] R;
  logic [DW-1:0] S;
  logic [3:0]    Alu_OP;

  int n_vec = 0;
  int n_err = 0;

  operand_fetch #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .RA(RA), .SA(SA), .Imm(Imm), .S_Sel(S_Sel), .Op_In(Op_In),
    .W_En(W_En), .WA(WA), .WD(WD), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .S(S), .Alu_OP(Alu_OP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an array of registers and a single held operand set.
  logic [DW-1:0] m_regs [8];
  logic          m_valid;
  logic [DW-1:0] m_r;
  logic [DW-1:0] m_s;
  logic [3:0]    m_op;
  bit            m_live = 0;

  function automatic logic [DW-1:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return '0;
    if (W_En && WA == a) return WD;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_valid = 0; m_r = '0; m_s = '0; m_op = '0;
      m_live  = 1;
    end else if (m_live) begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_valid = 1;
        m_r     = m_read(RA);
        m_s     = S_Sel ? Imm : m_read(SA);
        m_op    = Op_In;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (W_En && WA != 3'd0) m_regs[WA] = WD;
    end
  end

  // Compare process: every cycle once the model has been reset.
  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("R", 32'(R), 32'(m_r));
      chk("S", 32'(S), 32'(m_s));
      chk("Alu_OP", 32'(Alu_OP), 32'(m_op));
    end
  end

  task automatic idle();
    in_valid = 0; RA = 0; SA = 0; Imm = 0; S_Sel = 0; Op_In = 0;
    W_En = 0; WA = 0; WD = 0; out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1;
    idle();
    out_ready = 0;
    tick(); tick();
    reset = 0;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst R", 32'(R), 32'd0);
    chk("rst S", 32'(S), 32'd0);
    out_ready = 1;

    // Basic fetch from two registers
    W_En = 1; WA = 3; WD = 16'h1234; tick();
    WA = 5; WD = 16'h00FF; tick();
    W_En = 0; in_valid = 1; RA = 3; SA = 5; S_Sel = 0; Op_In = 4'b0010; tick();
    in_valid = 0;
    chk("basic out_valid", 32'(out_valid), 32'd1);
    chk("basic R", 32'(R), 32'h1234);
    chk("basic S", 32'(S), 32'h00FF);
    chk("basic Alu_OP", 32'(Alu_OP), 32'h2);

    // Bypass of a same-cycle write
    W_En = 1; WA = 2; WD = 16'hBEEF; in_valid = 1; RA = 2; SA = 3; tick();
    W_En = 0; in_valid = 0;
    chk("bypass R", 32'(R), 32'hBEEF);
    chk("bypass S", 32'(S), 32'h1234);

    // Register 0 ignores writes, including same-cycle bypass
    W_En = 1; WA = 0; WD = 16'hFFFF; tick();
    in_valid = 1; RA = 0; SA = 0; tick();
    W_En = 0; in_valid = 0;
    chk("r0 R", 32'(R), 32'h0);
    chk("r0 S", 32'(S), 32'h0);

    // Stall with a write during the stall
    in_valid = 1; RA = 3; SA = 5; Op_In = 4'h1; tick();
    chk("pre-stall R", 32'(R), 32'h1234);
    out_ready = 0; RA = 3; SA = 3;
    W_En = 1; WA = 3; WD = 16'h5555;
    #1 chk("stall in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      W_En = 0;
      chk("stall R", 32'(R), 32'h1234);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    #1 chk("release in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("release R", 32'(R), 32'h5555);
    chk("release S", 32'(S), 32'h5555);

    // Back-to-back immediates
    in_valid = 1; S_Sel = 1; Imm = 16'h0007; tick();
    chk("imm1 valid", 32'(out_valid), 32'd1);
    chk("imm1 S", 32'(S), 32'h0007);
    Imm = 16'h0009; tick();
    chk("imm2 valid", 32'(out_valid), 32'd1);
    chk("imm2 S", 32'(S), 32'h0009);
    in_valid = 0; S_Sel = 0; tick();
    chk("drain valid", 32'(out_valid), 32'd0);
    chk("drain S hold", 32'(S), 32'h0009);

    // Reset while a stalled set is pending
    in_valid = 1; RA = 3; Op_In = 4'hA; tick();
    chk("pend R", 32'(R), 32'h5555);
    in_valid = 0; out_ready = 0; reset = 1; tick();
    reset = 0; out_ready = 1;
    chk("mid-rst valid", 32'(out_valid), 32'd0);
    chk("mid-rst R", 32'(R), 32'h0);
    chk("mid-rst S", 32'(S), 32'h0);
    chk("mid-rst op", 32'(Alu_OP), 32'h0);
    for (int i = 1; i < 8; i++) begin
      in_valid = 1; RA = 3'(i); SA = 3'(i); S_Sel = 0; tick();
      chk("post-rst reg R", 32'(R), 32'h0);
      chk("post-rst reg S", 32'(S), 32'h0);
    end
    idle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      RA        = 3'($urandom);
      SA        = 3'($urandom);
      Imm       = 16'($urandom);
      S_Sel     = 1'($urandom);
      Op_In     = 4'($urandom);
      W_En      = 1'($urandom);
      WA        = 3'($urandom);
      WD        = 16'($urandom);
      tick();
    end
    reset = 0;
    idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
